// File: rtl/loopback_driver.sv
// Call sequencer for the loopback HLS component: issues a run of consecutive
// idx calls, consumes the in-order returns and reports checksum/mismatch/timeout.
module loopback_driver #(
  parameter int TIMEOUT = 1024,
  parameter int OUT_W   = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic [31:0] base_idx,
  input  logic [31:0] count,
  input  logic        ret_hold,
  output logic        lb_start,
  input  logic        lb_busy,
  output logic [31:0] lb_idx,
  input  logic        lb_done,
  output logic        lb_stall,
  input  logic [31:0] lb_returndata,
  output logic        running,
  output logic        finished,
  output logic        error,
  output logic [31:0] checksum,
  output logic [15:0] mismatch_cnt,
  output logic        first_bad_valid,
  output logic [31:0] first_bad_idx
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX   = '1;
  localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      exp_idx_q, exp_idx_d;
  logic [31:0]      remaining_q, remaining_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      checksum_q, checksum_d;
  logic [15:0]      mism_q, mism_d;
  logic             fb_valid_q, fb_valid_d;
  logic [31:0]      fb_idx_q, fb_idx_d;

  logic active, call_acc, ret_acc, spurious, ret_ok, timed_out;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    active    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    lb_start  = (state_q == S_ISSUE) && (remaining_q != 32'd0) && (out_q != OUT_MAX);
    call_acc  = lb_start && !lb_busy;
    ret_acc   = active && lb_done && !ret_hold;
    // A return with nothing outstanding is a protocol violation, not data.
    spurious  = ret_acc && (out_q == '0);
    ret_ok    = ret_acc && !spurious;

    state_d     = state_q;
    idx_d       = idx_q;
    exp_idx_d   = exp_idx_q;
    remaining_d = remaining_q;
    out_d       = out_q;
    checksum_d  = checksum_q;
    mism_d      = mism_q;
    fb_valid_d  = fb_valid_q;
    fb_idx_d    = fb_idx_q;

    if (call_acc) begin
      idx_d       = idx_q + 32'd1;
      remaining_d = remaining_q - 32'd1;
    end

    case ({call_acc, ret_ok})
      2'b10:   out_d = out_q + OUT_ONE;
      2'b01:   out_d = out_q - OUT_ONE;
      default: out_d = out_q;
    endcase

    if (ret_ok) begin
      checksum_d = checksum_q + lb_returndata;
      exp_idx_d  = exp_idx_q + 32'd1;
      if (lb_returndata != exp_idx_q) begin
        mism_d = sat_inc16(mism_q);
        if (!fb_valid_q) begin
          fb_valid_d = 1'b1;
          fb_idx_d   = exp_idx_q;
        end
      end
    end

    // Counts every cycle a return is owed but not taken, ret_hold stalls included.
    if (active && (out_q != '0) && !ret_acc) tmo_d = tmo_q + TMO_ONE;
    else                                     tmo_d = '0;
    timed_out = (tmo_d == TMO_LIMIT);

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (run) begin
          state_d     = (count == 32'd0) ? S_DONE : S_ISSUE;
          idx_d       = base_idx;
          exp_idx_d   = base_idx;
          remaining_d = count;
          out_d       = '0;
          tmo_d       = '0;
          checksum_d  = '0;
          mism_d      = '0;
          fb_valid_d  = 1'b0;
          fb_idx_d    = '0;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (spurious || timed_out)      state_d = S_ERROR;
        else if (remaining_d == 32'd0)  state_d = (out_d == '0) ? S_DONE : S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      exp_idx_q   <= '0;
      remaining_q <= '0;
      out_q       <= '0;
      tmo_q       <= '0;
      checksum_q  <= '0;
      mism_q      <= '0;
      fb_valid_q  <= 1'b0;
      fb_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_idx_q   <= exp_idx_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      tmo_q       <= tmo_d;
      checksum_q  <= checksum_d;
      mism_q      <= mism_d;
      fb_valid_q  <= fb_valid_d;
      fb_idx_q    <= fb_idx_d;
    end
  end

  assign lb_idx          = idx_q;
  assign lb_stall        = ret_hold;
  assign running         = active;
  assign finished        = (state_q == S_DONE);
  assign error           = (state_q == S_ERROR);
  assign checksum        = checksum_q;
  assign mismatch_cnt    = mism_q;
  assign first_bad_valid = fb_valid_q;
  assign first_bad_idx   = fb_idx_q;

endmodule
